// File: rtl/dmi_arb_pkg.sv
// Shared types and constants for the two-port DMI arbiter: FSM states,
// JTAG status codes and the arbitration helper used by the top.
package dmi_arb_pkg;

    localparam int DMI_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic [1:0] DMI_OK   = 2'b00;
    localparam logic [1:0] DMI_DROP = 2'b11;

    // H wins when it is the only requester, or on a tie when J was served last.
    function automatic logic pick_host(input logic jpend, input logic h_valid,
                                       input logic last_h);
        return h_valid && (!jpend || !last_h);
    endfunction

endpackage

// File: rtl/dmi_arbiter_if.sv
// Bundle of the JTAG request port, the host valid/ready port and the DMI
// register port. The arbiter uses the slave view; requesters and DMI use master.
interface dmi_arbiter_if #(
    parameter int AWIDTH = 7
);
    logic              j_en;
    logic              j_wr_en;
    logic [AWIDTH-1:0] j_addr;
    logic [31:0]       j_wdata;
    logic [31:0]       j_rdata;
    logic [1:0]        j_status;

    logic              h_valid;
    logic              h_ready;
    logic              h_we;
    logic [AWIDTH-1:0] h_addr;
    logic [31:0]       h_wdata;
    logic              h_rvalid;
    logic [31:0]       h_rdata;

    logic              dmi_reg_en;
    logic              dmi_reg_wr_en;
    logic [AWIDTH-1:0] dmi_reg_addr;
    logic [31:0]       dmi_reg_wdata;
    logic [31:0]       dmi_reg_rdata;

    modport slave (
        input  j_en, j_wr_en, j_addr, j_wdata,
        output j_rdata, j_status,
        input  h_valid, h_we, h_addr, h_wdata,
        output h_ready, h_rvalid, h_rdata,
        output dmi_reg_en, dmi_reg_wr_en, dmi_reg_addr, dmi_reg_wdata,
        input  dmi_reg_rdata
    );

    modport master (
        output j_en, j_wr_en, j_addr, j_wdata,
        input  j_rdata, j_status,
        output h_valid, h_we, h_addr, h_wdata,
        input  h_ready, h_rvalid, h_rdata,
        input  dmi_reg_en, dmi_reg_wr_en, dmi_reg_addr, dmi_reg_wdata,
        output dmi_reg_rdata
    );

endinterface

// File: rtl/dmi_req_slot.sv
// One-entry holding register for JTAG requests. A pulse that arrives while
// the slot is still occupied is discarded and flagged with a sticky status.
module dmi_req_slot
    import dmi_arb_pkg::*;
#(
    parameter int AWIDTH = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              j_en,
    input  logic              j_wr_en,
    input  logic [AWIDTH-1:0] j_addr,
    input  logic [31:0]       j_wdata,
    input  logic              clr,
    output logic              jpend,
    output logic              slot_we,
    output logic [AWIDTH-1:0] slot_addr,
    output logic [31:0]       slot_wdata,
    output logic [1:0]        status
);

    typedef struct packed {
        logic              we;
        logic [AWIDTH-1:0] addr;
        logic [31:0]       wdata;
    } req_t;

    req_t       slot_d, slot_q;
    logic       jpend_d, jpend_q;
    logic [1:0] status_d, status_q;

    always_comb begin
        slot_d   = slot_q;
        jpend_d  = jpend_q;
        status_d = status_q;
        if (clr) begin
            jpend_d = 1'b0;
        end
        // clr only fires while occupied, so a pulse in that cycle is a drop
        if (j_en) begin
            if (jpend_q) begin
                status_d = DMI_DROP;
            end else begin
                jpend_d      = 1'b1;
                status_d     = DMI_OK;
                slot_d.we    = j_wr_en;
                slot_d.addr  = j_addr;
                slot_d.wdata = j_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jpend_q  <= 1'b0;
            status_q <= DMI_OK;
        end else begin
            jpend_q  <= jpend_d;
            status_q <= status_d;
        end
    end

    // Payload is qualified by jpend, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign jpend      = jpend_q;
    assign slot_we    = slot_q.we;
    assign slot_addr  = slot_q.addr;
    assign slot_wdata = slot_q.wdata;
    assign status     = status_q;

endmodule

// File: rtl/dmi_arbiter.sv
// Serializes the JTAG and host debug ports onto one DMI register port,
// waits a fixed read latency and returns the completion to the requester.
module dmi_arbiter
    import dmi_arb_pkg::*;
#(
    parameter int AWIDTH = 7,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          rst,
    dmi_arbiter_if.slave bus
);

    typedef struct packed {
        logic              we;
        logic [AWIDTH-1:0] addr;
        logic [DMI_DW-1:0] wdata;
    } req_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    arb_state_e        state_d, state_q;
    logic              last_d, last_q;
    logic              gnt_h_d, gnt_h_q;
    logic [2:0]        cnt_d, cnt_q;
    logic              dmi_en_d, dmi_en_q;
    logic              dmi_wr_d, dmi_wr_q;
    logic [AWIDTH-1:0] dmi_addr_d, dmi_addr_q;
    logic [DMI_DW-1:0] dmi_wdata_d, dmi_wdata_q;
    logic [DMI_DW-1:0] j_rdata_d, j_rdata_q;
    logic              h_rvalid_d, h_rvalid_q;
    logic [DMI_DW-1:0] h_rdata_d, h_rdata_q;

    logic              jpend;
    logic              slot_we;
    logic [AWIDTH-1:0] slot_addr;
    logic [DMI_DW-1:0] slot_wdata;
    logic [1:0]        j_status;
    logic              slot_clr;
    logic              host_win;
    req_t              req_sel;

    dmi_req_slot #(
        .AWIDTH (AWIDTH)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .j_en       (bus.j_en),
        .j_wr_en    (bus.j_wr_en),
        .j_addr     (bus.j_addr),
        .j_wdata    (bus.j_wdata),
        .clr        (slot_clr),
        .jpend      (jpend),
        .slot_we    (slot_we),
        .slot_addr  (slot_addr),
        .slot_wdata (slot_wdata),
        .status     (j_status)
    );

    assign host_win = pick_host(jpend, bus.h_valid, last_q);

    always_comb begin
        if (host_win) begin
            req_sel.we    = bus.h_we;
            req_sel.addr  = bus.h_addr;
            req_sel.wdata = bus.h_wdata;
        end else begin
            req_sel.we    = slot_we;
            req_sel.addr  = slot_addr;
            req_sel.wdata = slot_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_h_d     = gnt_h_q;
        cnt_d       = cnt_q;
        dmi_en_d    = 1'b0;
        dmi_wr_d    = 1'b0;
        dmi_addr_d  = dmi_addr_q;
        dmi_wdata_d = dmi_wdata_q;
        j_rdata_d   = j_rdata_q;
        h_rvalid_d  = 1'b0;
        h_rdata_d   = h_rdata_q;
        slot_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (jpend || bus.h_valid) begin
                    gnt_h_d     = host_win;
                    dmi_en_d    = 1'b1;
                    dmi_wr_d    = req_sel.we;
                    dmi_addr_d  = req_sel.addr;
                    dmi_wdata_d = req_sel.wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // dmi_wr_q still carries the granted write qualifier here
                if (dmi_wr_q) begin
                    state_d = RESP;
                    if (gnt_h_q) begin
                        h_rvalid_d = 1'b1;
                        h_rdata_d  = '0;
                    end
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    if (gnt_h_q) begin
                        h_rvalid_d = 1'b1;
                        h_rdata_d  = bus.dmi_reg_rdata;
                    end else begin
                        j_rdata_d = bus.dmi_reg_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                slot_clr = !gnt_h_q;
                last_d   = gnt_h_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt_h_q     <= 1'b0;
            cnt_q       <= 3'd0;
            dmi_en_q    <= 1'b0;
            dmi_wr_q    <= 1'b0;
            dmi_addr_q  <= '0;
            dmi_wdata_q <= '0;
            j_rdata_q   <= '0;
            h_rvalid_q  <= 1'b0;
            h_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt_h_q     <= gnt_h_d;
            cnt_q       <= cnt_d;
            dmi_en_q    <= dmi_en_d;
            dmi_wr_q    <= dmi_wr_d;
            dmi_addr_q  <= dmi_addr_d;
            dmi_wdata_q <= dmi_wdata_d;
            j_rdata_q   <= j_rdata_d;
            h_rvalid_q  <= h_rvalid_d;
            h_rdata_q   <= h_rdata_d;
        end
    end

    // The host handshake is decided in the same cycle the grant is taken.
    assign bus.h_ready       = !rst && (state_q == IDLE) && host_win;
    assign bus.h_rvalid      = h_rvalid_q;
    assign bus.h_rdata       = h_rdata_q;
    assign bus.j_rdata       = j_rdata_q;
    assign bus.j_status      = j_status;
    assign bus.dmi_reg_en    = dmi_en_q;
    assign bus.dmi_reg_wr_en = dmi_wr_q;
    assign bus.dmi_reg_addr  = dmi_addr_q;
    assign bus.dmi_reg_wdata = dmi_wdata_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed bench for dmi_arbiter: a cycle table on an RD_LAT=1 instance plus
// hand sequences for arbitration order, long read latency and mid-transfer reset.
module tb_dmi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [31:0] JK = 32'h1234_5678;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] CF = 32'hCAFE_0005;
    localparam logic [31:0] W1 = 32'h8000_0001;
    localparam logic [31:0] R4 = 32'hA5A5_0004;

    always #5 clk = ~clk;

    dmi_arbiter_if #(.AWIDTH(7)) bus1 ();
    dmi_arbiter_if #(.AWIDTH(7)) bus4 ();

    dmi_arbiter #(.AWIDTH(7), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmi_arbiter #(.AWIDTH(7), .RD_LAT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic        j_en;
        logic        j_we;
        logic [6:0]  j_addr;
        logic [31:0] j_wdata;
        logic        h_valid;
        logic        h_we;
        logic [6:0]  h_addr;
        logic [31:0] h_wdata;
        logic [31:0] rdata;
        logic        e_en;
        logic        e_wr;
        logic [6:0]  e_addr;
        logic [31:0] e_wdata;
        logic        e_hready;
        logic        e_hrvalid;
        logic [31:0] e_hrdata;
        logic [31:0] e_jrdata;
        logic [1:0]  e_jstatus;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr_inputs();
        bus1.j_en = 1'b0; bus1.j_wr_en = 1'b0; bus1.j_addr = '0; bus1.j_wdata = '0;
        bus1.h_valid = 1'b0; bus1.h_we = 1'b0; bus1.h_addr = '0; bus1.h_wdata = '0;
        bus1.dmi_reg_rdata = JK;
        bus4.j_en = 1'b0; bus4.j_wr_en = 1'b0; bus4.j_addr = '0; bus4.j_wdata = '0;
        bus4.h_valid = 1'b0; bus4.h_we = 1'b0; bus4.h_addr = '0; bus4.h_wdata = '0;
        bus4.dmi_reg_rdata = JK;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        clr_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] got [4];
        logic [6:0] exp_alt [4];
        int         ng;
        logic       found;
        logic       acc;
        logic       saw_en;
        logic       saw_rv;

        // j_en j_we j_addr j_wdata | h_valid h_we h_addr h_wdata | rdata ||
        // en wr addr wdata | h_ready h_rvalid h_rdata j_rdata j_status
        tbl[0]  = '{1'b1, 1'b1, 7'h10, W1,          1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[1]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[2]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b1, 1'b1, 7'h10, W1,    1'b0, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[3]  = '{1'b1, 1'b0, 7'h20, 32'h0000_0BAD, 1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h10, W1,    1'b0, 1'b0, 32'h0, 32'h0, 2'b00};
        tbl[4]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b1, 1'b0, 7'h11, 32'h0, JK,
                    1'b0, 1'b0, 7'h10, W1,    1'b1, 1'b0, 32'h0, 32'h0, 2'b11};
        tbl[5]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b1, 1'b0, 7'h11, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11};
        tbl[6]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, DB,
                    1'b0, 1'b0, 7'h11, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11};
        tbl[7]  = '{1'b1, 1'b0, 7'h05, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h11, 32'h0, 1'b0, 1'b1, DB,    32'h0, 2'b11};
        tbl[8]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h11, 32'h0, 1'b0, 1'b0, DB,    32'h0, 2'b00};
        tbl[9]  = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b1, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, DB,    32'h0, 2'b00};
        tbl[10] = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, CF,
                    1'b0, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, DB,    32'h0, 2'b00};
        tbl[11] = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, DB,    CF,    2'b00};
        tbl[12] = '{1'b0, 1'b0, 7'h00, 32'h0,       1'b0, 1'b0, 7'h00, 32'h0, JK,
                    1'b0, 1'b0, 7'h05, 32'h0, 1'b0, 1'b0, DB,    CF,    2'b00};

        clr_inputs();
        do_reset();

        // Cycle table: J write, dropped J pulse, H read, J read.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            bus1.j_en    = tbl[i].j_en;
            bus1.j_wr_en = tbl[i].j_we;
            bus1.j_addr  = tbl[i].j_addr;
            bus1.j_wdata = tbl[i].j_wdata;
            bus1.h_valid = tbl[i].h_valid;
            bus1.h_we    = tbl[i].h_we;
            bus1.h_addr  = tbl[i].h_addr;
            bus1.h_wdata = tbl[i].h_wdata;
            bus1.dmi_reg_rdata = tbl[i].rdata;
            @(negedge clk);
            chk($sformatf("row%0d dmi_reg_en", i),    32'(bus1.dmi_reg_en),    32'(tbl[i].e_en));
            chk($sformatf("row%0d dmi_reg_wr_en", i), 32'(bus1.dmi_reg_wr_en), 32'(tbl[i].e_wr));
            chk($sformatf("row%0d dmi_reg_addr", i),  32'(bus1.dmi_reg_addr),  32'(tbl[i].e_addr));
            chk($sformatf("row%0d dmi_reg_wdata", i), bus1.dmi_reg_wdata,      tbl[i].e_wdata);
            chk($sformatf("row%0d h_ready", i),       32'(bus1.h_ready),       32'(tbl[i].e_hready));
            chk($sformatf("row%0d h_rvalid", i),      32'(bus1.h_rvalid),      32'(tbl[i].e_hrvalid));
            chk($sformatf("row%0d h_rdata", i),       bus1.h_rdata,            tbl[i].e_hrdata);
            chk($sformatf("row%0d j_rdata", i),       bus1.j_rdata,            tbl[i].e_jrdata);
            chk($sformatf("row%0d j_status", i),      32'(bus1.j_status),      32'(tbl[i].e_jstatus));
        end

        // Both ports requesting continuously: grants must alternate J,H,J,H.
        do_reset();
        @(negedge clk);
        chk("rst4 dmi_reg_en",   32'(bus4.dmi_reg_en),   32'h0);
        chk("rst4 dmi_reg_addr", 32'(bus4.dmi_reg_addr), 32'h0);
        chk("rst4 j_status",     32'(bus4.j_status),     32'h0);
        chk("rst4 h_rvalid",     32'(bus4.h_rvalid),     32'h0);
        exp_alt[0] = 7'h01; exp_alt[1] = 7'h02; exp_alt[2] = 7'h01; exp_alt[3] = 7'h02;
        @(posedge clk); #1;
        bus1.j_en = 1'b1; bus1.j_wr_en = 1'b1; bus1.j_addr = 7'h01; bus1.j_wdata = 32'h1;
        @(posedge clk); #1;
        bus1.h_valid = 1'b1; bus1.h_we = 1'b1; bus1.h_addr = 7'h02; bus1.h_wdata = 32'h2;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            @(negedge clk);
            if (bus1.dmi_reg_en) begin
                got[ng] = bus1.dmi_reg_addr;
                ng++;
            end
        end
        chk("alt grant count", 32'(ng), 32'd4);
        for (int k = 0; k < ng; k++)
            chk($sformatf("alt grant%0d addr", k), 32'(got[k]), 32'(exp_alt[k]));
        clr_inputs();

        // RD_LAT=4 J read: sample 4 cycles after dmi_reg_en, j_rdata one later.
        do_reset();
        @(posedge clk); #1;
        bus4.j_en = 1'b1; bus4.j_wr_en = 1'b0; bus4.j_addr = 7'h04; bus4.j_wdata = 32'h0;
        @(posedge clk); #1;
        bus4.j_en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            found = bus4.dmi_reg_en;
        end
        chk("lat4 dmi_reg_en seen", 32'(found), 32'h1);
        chk("lat4 dmi_reg_addr",    32'(bus4.dmi_reg_addr),  32'h04);
        chk("lat4 dmi_reg_wr_en",   32'(bus4.dmi_reg_wr_en), 32'h0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            bus4.dmi_reg_rdata = (k == 4) ? R4 : JK;
            @(negedge clk);
            chk($sformatf("lat4 +%0d en low", k), 32'(bus4.dmi_reg_en), 32'h0);
            if (k == 4) chk("lat4 j_rdata at sample", bus4.j_rdata, 32'h0);
            if (k == 5) chk("lat4 j_rdata after",     bus4.j_rdata, R4);
        end

        // Reset during WAIT with a buffered J request behind the host read.
        @(posedge clk); #1;
        bus4.dmi_reg_rdata = JK;
        bus4.h_valid = 1'b1; bus4.h_we = 1'b0; bus4.h_addr = 7'h33; bus4.h_wdata = 32'h0;
        acc = 1'b0;
        for (int c = 0; c < 10 && !acc; c++) begin
            @(negedge clk);
            acc = bus4.h_ready;
        end
        chk("rstw h_ready seen", 32'(acc), 32'h1);
        @(posedge clk); #1;
        bus4.h_valid = 1'b0;
        bus4.j_en = 1'b1; bus4.j_wr_en = 1'b1; bus4.j_addr = 7'h3C; bus4.j_wdata = 32'h77;
        @(posedge clk); #1;
        bus4.j_en = 1'b0;
        @(posedge clk); #2;
        chk("rstw pre dmi_reg_addr", 32'(bus4.dmi_reg_addr), 32'h33);
        rst = 1'b1;
        bus4.h_valid = 1'b1;
        #1;
        chk("rstw dmi_reg_en",    32'(bus4.dmi_reg_en),    32'h0);
        chk("rstw dmi_reg_wr_en", 32'(bus4.dmi_reg_wr_en), 32'h0);
        chk("rstw dmi_reg_addr",  32'(bus4.dmi_reg_addr),  32'h0);
        chk("rstw dmi_reg_wdata", bus4.dmi_reg_wdata,      32'h0);
        chk("rstw h_ready",       32'(bus4.h_ready),       32'h0);
        chk("rstw h_rvalid",      32'(bus4.h_rvalid),      32'h0);
        chk("rstw h_rdata",       bus4.h_rdata,            32'h0);
        chk("rstw j_rdata",       bus4.j_rdata,            32'h0);
        chk("rstw j_status",      32'(bus4.j_status),      32'h0);
        repeat (2) @(posedge clk);
        #1 bus4.h_valid = 1'b0;
        rst = 1'b0;
        saw_en = 1'b0;
        saw_rv = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            saw_en = saw_en | bus4.dmi_reg_en;
            saw_rv = saw_rv | bus4.h_rvalid;
        end
        chk("post-rst no dmi_reg_en", 32'(saw_en), 32'h0);
        chk("post-rst no h_rvalid",   32'(saw_rv), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
